mul56_seq: RTL and testbench
============================

# mul56_seq

Sequential 56x56 unsigned multiplier for the FPU significand path. Each operand is split into four 14-bit digits. The 16 digit-pair products are issued one per cycle through a single internal ce-gated 14x14 registered multiplier, and a 112-bit accumulator sums them. The block trades latency for area and sits between the significand-alignment logic and the normalise/round stage.

## Interface
- Parameters: none. Widths are fixed: 56-bit operands, 14-bit digits, 112-bit product.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  start request; sampled only in IDLE.
- a  in  56  multiplicand; latched on acceptance.
- b  in  56  multiplier; latched on acceptance.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse; o is valid from this cycle onward.
- o  out  112  product a*b; held until the next done.

## Operation
- Digits: a_d[i] = a_q[14i+13:14i], b_d[j] likewise, with i,j in 0..3.
- Issue counter k runs 0..15; i = k[3:2], j = k[1:0].
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - req=1 latches a_q/b_q, clears acc, sets k=0, and moves to RUN.
  - req=0 stays in IDLE.
- RUN, each cycle:
  - Drives multiplier inputs a_d[i], b_d[j] with ce=1 and increments k.
  - A one-bit valid flag, delayed one cycle, marks a fresh product.
  - When the flag is set: acc <= acc + (pp << 14*(i'+j')), where i',j' are the indices of the previous issue.
  - After the k=15 issue, moves to DRAIN.
- DRAIN: accumulates the last product. o <= final sum, done <= 1, state moves to IDLE.
- Arithmetic: all unsigned, 112-bit. Overflow is impossible; no carry out.
- The multiplier's product register has no reset. The valid flag gates every accumulation, so a stale product is never summed.
- req while busy: ignored.
- a/b changes after acceptance: ignored.
- Reset (asynchronous, including mid-operation):
  - state=IDLE, busy=0, done=0, o=0, acc=0, k=0, valid=0.
  - An in-flight operation is discarded.

## Timing
- Let E0 be the edge that samples req=1 in IDLE.
- Issues at edges E1..E16; accumulations at edges E2..E17.
- E17 registers o and done=1. done is high in the cycle after E17 and low after E18.
- Latency: 17 cycles from acceptance to done.
- busy is high in the cycles following E0..E16 and low from E17.
- Back-to-back: a req presented while done=1 is accepted at E18, giving one result every 18 cycles.
- o changes only at the done edge (or on reset).

## Configuration
- MUL56_ZERO_BYPASS_EN defined:
  - If a==0 or b==0 at acceptance, go IDLE→DONE directly: o <= 0 and done=1 after E1; the multiplier is not clocked (ce=0).
  - Nonzero operands take the normal 17-cycle path.
- Undefined: every operation takes 17 cycles, including zero operands.

## Test plan
- a=1, b=1, req at E0 → busy for 17 cycles, done pulse after E17, o=1.
- a=b=0xFFFFFFFFFFFFFF → o=0xFFFFFFFFFFFFFE00000000000001.
- a=2^55, b=2^55 → o=2^110 (cross-digit shift check). Also a=0x3FFF, b=2^42 → o=0x3FFF<<42.
- a=3, b=5 accepted, then a=7, b=7 and req=1 held during busy → o=15, exactly one done; the next req is accepted at E18.
- rst_n low for one cycle at E8 of an operation → busy, done and o read 0 immediately and no done follows; a new req with a=6, b=7 → o=42 after 17 cycles.
- a=0, b=5 → with MUL56_ZERO_BYPASS_EN: done after E1, o=0; without: done after E17, o=0.

Source files
------------

// File: rtl/mul56_seq_if.sv
// Start/operand/result bundle for the sequential 56x56 significand multiplier.
interface mul56_seq_if;
    logic         req;
    logic [55:0]  a;
    logic [55:0]  b;
    logic         busy;
    logic         done;
    logic [111:0] o;

    modport master (output req, a, b, input busy, done, o);
    modport slave  (input req, a, b, output busy, done, o);
endinterface

// File: rtl/mul56_seq.sv
// Sequential 56x56 unsigned multiplier: 16 digit products through one 14x14 registered multiplier.
// Optional MUL56_ZERO_BYPASS_EN: zero operands skip the multiply and finish in one cycle.
module mul56_seq (
    input  logic       clk,
    input  logic       rst_n,
    mul56_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t       state_q, state_d;
    logic [55:0]  a_q, b_q;
    logic [3:0]   k_q, k_d;
    logic         vld_q;
    logic [1:0]   ip_q, jp_q;
    logic [27:0]  pp_q;
    logic [111:0] acc_q, acc_d, acc_sum;
    logic [111:0] o_q, o_d;
    logic         done_q, done_d;
    logic         busy, accept, mul_ce;
    logic [13:0]  mul_a, mul_b;

    // Weight a digit-pair product by 14*(i+j) bits; max shift 84 keeps it inside 112 bits.
    function automatic logic [111:0] place_pp(input logic [27:0] pp,
                                              input logic [1:0]  i,
                                              input logic [1:0]  j);
        logic [2:0] dsum;
        logic [6:0] sh;
        dsum = {1'b0, i} + {1'b0, j};
        sh   = 7'd14 * {4'd0, dsum};
        return {84'd0, pp} << sh;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
`ifdef MUL56_ZERO_BYPASS_EN
                    if ((bus.a == 56'd0) || (bus.b == 56'd0)) state_d = DONE;
                    else                                      state_d = RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN:     if (k_q == 4'd15) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        accept = (state_q == IDLE) && bus.req;
        mul_ce = (state_q == RUN);
    end

    assign mul_a   = a_q[14*k_q[3:2] +: 14];
    assign mul_b   = b_q[14*k_q[1:0] +: 14];
    assign acc_sum = acc_q + (vld_q ? place_pp(pp_q, ip_q, jp_q) : 112'd0);

    always_comb begin
        k_d    = k_q;
        acc_d  = acc_sum;
        o_d    = o_q;
        done_d = 1'b0;
        if (accept) begin
            k_d   = 4'd0;
            acc_d = 112'd0;
        end else if (mul_ce) begin
            k_d = k_q + 4'd1;
        end
        if (state_q == DRAIN) begin
            o_d    = acc_sum;
            done_d = 1'b1;
        end else if (state_q == DONE) begin
            o_d    = 112'd0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= 4'd0;
            vld_q  <= 1'b0;
            acc_q  <= 112'd0;
            o_q    <= 112'd0;
            done_q <= 1'b0;
        end else begin
            k_q    <= k_d;
            vld_q  <= mul_ce;
            acc_q  <= acc_d;
            o_q    <= o_d;
            done_q <= done_d;
        end
    end

    // Operand latches and the multiplier product register carry no reset; vld_q guards the sum.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= bus.a;
            b_q <= bus.b;
        end
        if (mul_ce) begin
            pp_q <= {14'd0, mul_a} * {14'd0, mul_b};
            ip_q <= k_q[3:2];
            jp_q <= k_q[1:0];
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.o    = o_q;
endmodule

// File: tb/tb_mul56_seq.sv
// Directed bench for mul56_seq: latency, products, back-to-back, mid-operation reset, zero operands.
module tb_mul56_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mul56_seq_if bus ();

    mul56_seq dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for done; returns latency in cycles after E0.
    task automatic run_op(input logic [55:0] av, input logic [55:0] bv,
                          output int lat, output int busy_low, output logic [111:0] res);
        bus.a   = av;
        bus.b   = bv;
        bus.req = 1'b1;
        tick();
        bus.req  = 1'b0;
        lat      = 0;
        busy_low = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy !== 1'b1) busy_low++;
            tick();
            lat++;
        end
        res = bus.o;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        bus.req = 1'b0;
        bus.a   = '0;
        bus.b   = '0;
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.o !== 112'd0) begin errors++; $display("FAIL reset_o: got %h expected 0", bus.o); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_unit;
        int lat, bl;
        logic [111:0] res;
        run_op(56'd1, 56'd1, lat, bl, res);
        checks++; if (lat !== 17) begin errors++; $display("FAIL unit_latency: got %0d expected 17", lat); end
        checks++; if (bl !== 0) begin errors++; $display("FAIL unit_busy: got %0d low cycles expected 0", bl); end
        checks++; if (res !== 112'd1) begin errors++; $display("FAIL unit_o: got %h expected 1", res); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL unit_busy_at_done: got %b expected 0", bus.busy); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL unit_done_pulse: got %b expected 0", bus.done); end
        checks++; if (bus.o !== 112'd1) begin errors++; $display("FAIL unit_o_hold: got %h expected 1", bus.o); end
    endtask

    task automatic test_max;
        int lat, bl;
        logic [111:0] res;
        logic [111:0] exp_v;
        exp_v = 112'hFFFFFFFFFFFFFE00000000000001;
        run_op(56'hFFFFFFFFFFFFFF, 56'hFFFFFFFFFFFFFF, lat, bl, res);
        checks++; if (res !== exp_v) begin errors++; $display("FAIL max_o: got %h expected %h", res, exp_v); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL max_latency: got %0d expected 17", lat); end
        tick();
    endtask

    task automatic test_shift;
        int lat, bl;
        logic [111:0] res;
        logic [111:0] exp_v;
        exp_v = 112'd1 << 110;
        run_op(56'd1 << 55, 56'd1 << 55, lat, bl, res);
        checks++; if (res !== exp_v) begin errors++; $display("FAIL shift_top_o: got %h expected %h", res, exp_v); end
        tick();
        exp_v = 112'h3FFF << 42;
        run_op(56'h3FFF, 56'd1 << 42, lat, bl, res);
        checks++; if (res !== exp_v) begin errors++; $display("FAIL shift_digit_o: got %h expected %h", res, exp_v); end
        tick();
    endtask

    task automatic test_back_to_back;
        int n;
        bus.a   = 56'd3;
        bus.b   = 56'd5;
        bus.req = 1'b1;
        tick();
        bus.a = 56'd7;
        bus.b = 56'd7;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n !== 17) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 17", n); end
        checks++; if (bus.o !== 112'd15) begin errors++; $display("FAIL b2b_first_o: got %0d expected 15", bus.o); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_single_done: got %b expected 0", bus.done); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_e18: got %b expected 1", bus.busy); end
        bus.req = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n !== 17) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 17", n); end
        checks++; if (bus.o !== 112'd49) begin errors++; $display("FAIL b2b_second_o: got %0d expected 49", bus.o); end
        tick();
    endtask

    task automatic test_reset_mid;
        int lat, bl, seen;
        logic [111:0] res;
        bus.a   = 56'd9;
        bus.b   = 56'd9;
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        repeat (7) tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.o !== 112'd0) begin errors++; $display("FAIL mid_reset_o: got %h expected 0", bus.o); end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d done cycles expected 0", seen); end
        run_op(56'd6, 56'd7, lat, bl, res);
        checks++; if (res !== 112'd42) begin errors++; $display("FAIL after_reset_o: got %0d expected 42", res); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL after_reset_latency: got %0d expected 17", lat); end
        tick();
    endtask

    task automatic test_zero;
        int lat, bl, exp_lat;
        logic [111:0] res;
`ifdef MUL56_ZERO_BYPASS_EN
        exp_lat = 1;
`else
        exp_lat = 17;
`endif
        run_op(56'd0, 56'd5, lat, bl, res);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", lat, exp_lat); end
        checks++; if (res !== 112'd0) begin errors++; $display("FAIL zero_o: got %h expected 0", res); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b expected 0", bus.done); end
    endtask

    initial begin
        test_reset();
        test_unit();
        test_max();
        test_shift();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
